// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: streams the 15 round keys from an 8-word sliding window
// over a valid/ready handshake, using four combinational S-boxes for SubWord.

module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];
endmodule

module aes256_key_expand #(
    parameter int NUM_ROUND_KEYS = 15
) (
    input  logic           clk_i,
    input  logic           rst_i,
    input  logic           start_i,
    input  logic [255:0]   cipher_key_i,
    output logic           round_key_valid_o,
    input  logic           round_key_ready_i,
    output logic [127:0]   round_key_o,
    output logic [3:0]     round_idx_o,
    output logic           busy_o,
    output logic           done_o
);
    if (NUM_ROUND_KEYS != 15) begin : g_unsupported
        $error("aes256_key_expand: only NUM_ROUND_KEYS = 15 is supported");
    end

    localparam logic [3:0] LAST_IDX = 4'(NUM_ROUND_KEYS - 1);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t        state_q, state_d;
    logic [255:0]  win_q;
    logic [7:0]    rcon_q;
    logic [3:0]    idx_q;
    logic          done_q;

    logic          handshake;
    logic          last_key;
    logic          load;
    logic [31:0]   w [8];
    logic [31:0]   sub_in, sub_out, t;
    logic [31:0]   n0, n1, n2, n3;
    logic [7:0]    rcon_next;

    assign handshake = (state_q == RUN) && round_key_ready_i;
    assign last_key  = (idx_q == LAST_IDX);
    assign load      = (state_q == IDLE) && start_i;

    always_comb begin
        for (int i = 0; i < 8; i++) begin
            w[i] = win_q[255 - 32*i -: 32];
        end
    end

    // Even steps rotate and add rcon; odd steps (AES-256 only) substitute the raw word.
    assign sub_in = idx_q[0] ? w[7] : {w[7][23:0], w[7][31:24]};

    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .a (sub_in[8*b +: 8]),
            .y (sub_out[8*b +: 8])
        );
    end

    assign t  = idx_q[0] ? sub_out : (sub_out ^ {rcon_q, 24'h0});
    assign n0 = w[0] ^ t;
    assign n1 = w[1] ^ n0;
    assign n2 = w[2] ^ n1;
    assign n3 = w[3] ^ n2;

    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // NOTE: combinational next-state logic assigns every output a default first, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = RUN;
            RUN:  if (handshake && last_key) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: all state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            win_q  <= '0;
            rcon_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= handshake && last_key;
            if (load) begin
                win_q  <= cipher_key_i;
                rcon_q <= 8'h01;
                idx_q  <= '0;
            end else if (handshake && !last_key) begin
                win_q <= {win_q[127:0], n0, n1, n2, n3};
                idx_q <= idx_q + 4'd1;
                if (!idx_q[0]) rcon_q <= rcon_next;
            end
        end
    end

    assign round_key_o       = win_q[255:128];
    assign round_idx_o       = idx_q;
    assign round_key_valid_o = (state_q == RUN);
    assign busy_o            = (state_q == RUN);
    assign done_o            = done_q;
endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for aes256_key_expand against published AES-256 key schedules.

module tb_aes256_key_expand;
    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          start_i;
    logic [255:0]  cipher_key_i;
    logic          round_key_valid_o;
    logic          round_key_ready_i;
    logic [127:0]  round_key_o;
    logic [3:0]    round_idx_o;
    logic          busy_o;
    logic          done_o;

    int checks   = 0;
    int failures = 0;

    localparam logic [255:0] KEY_A = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KEY_B = 256'hdeadbeefcafef00d0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;

    logic [127:0] exp_a [15] = '{
        128'h000102030405060708090a0b0c0d0e0f,
        128'h101112131415161718191a1b1c1d1e1f,
        128'ha573c29fa176c498a97fce93a572c09c,
        128'h1651a8cd0244beda1a5da4c10640bade,
        128'hae87dff00ff11b68a68ed5fb03fc1567,
        128'h6de1f1486fa54f9275f8eb5373b8518d,
        128'hc656827fc9a799176f294cec6cd5598b,
        128'h3de23a75524775e727bf9eb45407cf39,
        128'h0bdc905fc27b0948ad5245a4c1871c2f,
        128'h45f5a66017b2d387300d4d33640a820a,
        128'h7ccff71cbeb4fe5413e6bbf0d261a7df,
        128'hf01afafee7a82979d7a5644ab3afe640,
        128'h2541fe719bf500258813bbd55a721c0a,
        128'h4e5a6699a9f24fe07e572baacdf8cdea,
        128'h24fc79ccbf0979e9371ac23c6d68de36
    };

    aes256_key_expand #(.NUM_ROUND_KEYS(15)) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_i           (start_i),
        .cipher_key_i      (cipher_key_i),
        .round_key_valid_o (round_key_valid_o),
        .round_key_ready_i (round_key_ready_i),
        .round_key_o       (round_key_o),
        .round_idx_o       (round_idx_o),
        .busy_o            (busy_o),
        .done_o            (done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Collects 15 keys of KEY_A; optionally randomises ready and injects a start at inject_at.
    task automatic stream(input bit rand_ready, input int inject_at, input logic [255:0] inject_key);
        int  count  = 0;
        int  cycles = 0;
        bit  hs;
        while (count < 15 && cycles < 200) begin
            round_key_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            start_i = 1'b0;
            if (round_key_valid_o && int'(round_idx_o) == inject_at) begin
                start_i      = 1'b1;
                cipher_key_i = inject_key;
            end
            if (!rand_ready) check("valid_continuous", 128'(round_key_valid_o), 128'd1);
            if (round_key_valid_o) begin
                check($sformatf("key%0d", count), round_key_o, exp_a[count]);
                check($sformatf("idx%0d", count), 128'(round_idx_o), 128'(count));
                check("done_low_in_run", 128'(done_o), 128'd0);
            end
            hs = round_key_valid_o && round_key_ready_i;
            tick();
            cycles++;
            if (hs) count++;
        end
        start_i = 1'b0;
        round_key_ready_i = 1'b1;
        check("key_count", 128'(count), 128'd15);
        if (!rand_ready) check("cycles_no_bubbles", 128'(cycles), 128'd15);
        check("done_pulse", 128'(done_o), 128'd1);
        check("valid_after_last", 128'(round_key_valid_o), 128'd0);
        check("busy_after_last", 128'(busy_o), 128'd0);
    endtask

    initial begin
        int budget;
        rst_i = 1'b1;
        start_i = 1'b0;
        cipher_key_i = '0;
        round_key_ready_i = 1'b0;
        #12;
        rst_i = 1'b0;
        tick();

        // Idle for 20 cycles after reset.
        for (int i = 0; i < 20; i++) begin
            check("idle_valid", 128'(round_key_valid_o), 128'd0);
            check("idle_busy", 128'(busy_o), 128'd0);
            check("idle_done", 128'(done_o), 128'd0);
            check("idle_key", round_key_o, 128'd0);
            tick();
        end

        // Continuous ready.
        cipher_key_i = KEY_A;
        start_i = 1'b1;
        tick();
        cipher_key_i = KEY_B;
        stream(1'b0, -1, KEY_A);
        tick();
        check("done_one_cycle", 128'(done_o), 128'd0);

        // Random ready pattern.
        cipher_key_i = KEY_A;
        start_i = 1'b1;
        tick();
        stream(1'b1, -1, KEY_A);
        tick();

        // Start with another key at idx 5 is ignored.
        cipher_key_i = KEY_A;
        start_i = 1'b1;
        tick();
        stream(1'b0, 5, KEY_B);
        tick();

        // Asynchronous reset mid-expansion at idx 7.
        cipher_key_i = '0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        budget = 0;
        while (round_idx_o != 4'd7 && budget < 30) begin
            tick();
            budget++;
        end
        check("reached_idx7", 128'(round_idx_o), 128'd7);
        #3;
        rst_i = 1'b1;
        #1;
        check("rst_valid", 128'(round_key_valid_o), 128'd0);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_done", 128'(done_o), 128'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_valid", 128'(round_key_valid_o), 128'd0);
        end

        // Restart with KEY_A, then back-to-back start in the done cycle with key 0.
        cipher_key_i = KEY_A;
        start_i = 1'b1;
        tick();
        stream(1'b0, -1, KEY_A);
        cipher_key_i = '0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("b2b_valid", 128'(round_key_valid_o), 128'd1);
        check("b2b_k0", round_key_o, 128'h0);
        tick();
        check("b2b_k1", round_key_o, 128'h0);
        tick();
        check("b2b_k2", round_key_o, 128'h62636363626363636263636362636363);
        tick();
        check("b2b_k3", round_key_o, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb);
        check("b2b_idx3", 128'(round_idx_o), 128'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
